// File: rtl/id_ctrl_pkg.sv
// Shared decode definitions for the ID control stage: opcode/func codes,
// ALU operation encoding and the packed control word carried into ID/EX.
package id_ctrl_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned FUNC_W = 6;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [FUNC_W-1:0] FN_ADD = 6'b100001;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'b100011;
    localparam logic [FUNC_W-1:0] FN_AND = 6'b100100;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FUNC_W-1:0] FN_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef struct packed {
        logic    regwr;
        logic    extop;
        logic    alusrc;
        logic    memwr;
        logic    memtoreg;
        logic    branch;
        logic    jump;
        alu_op_e aluc;
    } ctrl_word_t;

    // Control word of a bubble / killed slot: no side effects downstream.
    localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/id_stage_ctrl_if.sv
// ID -> EX handshake and control-word bus for id_stage_ctrl.
// ID_STAGE_CTRL_FWD_EN adds write-back destination inputs and registered
// forwarding selects; without it the MEM destination inputs feed the RAW check.
interface id_stage_ctrl_if #(
    parameter int unsigned ALUC_W = 3,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
);
    logic              if_valid;
    logic [31:0]       if_instr;
    logic              id_ready;
    logic              ex_stall;
    logic              flush;
    logic [REG_AW-1:0] mem_wreg;
    logic              mem_regwr;
`ifdef ID_STAGE_CTRL_FWD_EN
    logic [REG_AW-1:0] wb_wreg;
    logic              wb_regwr;
    logic [1:0]        ex_fwd_a;
    logic [1:0]        ex_fwd_b;
`endif
    logic              ex_valid;
    logic [REG_AW-1:0] ex_rs;
    logic [REG_AW-1:0] ex_rt;
    logic [REG_AW-1:0] ex_wreg;
    logic [15:0]       ex_imm;
    logic [5:0]        ex_func;
    logic [ALUC_W-1:0] ex_aluc;
    logic              ex_regwr;
    logic              ex_extop;
    logic              ex_alusrc;
    logic              ex_memwr;
    logic              ex_memtoreg;
    logic              ex_branch;
    logic              ex_jump;
    logic              ill_op;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;

    // The ID stage itself.
    modport slave (
        input  if_valid, if_instr, ex_stall, flush, mem_wreg, mem_regwr,
`ifdef ID_STAGE_CTRL_FWD_EN
        input  wb_wreg, wb_regwr,
        output ex_fwd_a, ex_fwd_b,
`endif
        output id_ready, ex_valid, ex_rs, ex_rt, ex_wreg, ex_imm, ex_func,
        output ex_aluc, ex_regwr, ex_extop, ex_alusrc, ex_memwr, ex_memtoreg,
        output ex_branch, ex_jump, ill_op, stall_cnt, bubble_cnt
    );

    // The surrounding pipeline (IF/ID register, EX, MEM/WB).
    modport master (
        output if_valid, if_instr, ex_stall, flush, mem_wreg, mem_regwr,
`ifdef ID_STAGE_CTRL_FWD_EN
        output wb_wreg, wb_regwr,
        input  ex_fwd_a, ex_fwd_b,
`endif
        input  id_ready, ex_valid, ex_rs, ex_rt, ex_wreg, ex_imm, ex_func,
        input  ex_aluc, ex_regwr, ex_extop, ex_alusrc, ex_memwr, ex_memtoreg,
        input  ex_branch, ex_jump, ill_op, stall_cnt, bubble_cnt
    );

endinterface

// File: rtl/id_decode.sv
// Pure combinational instruction decoder: control word, destination register,
// which source registers the instruction reads, and the illegal-opcode flag.
module id_decode
    import id_ctrl_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [FUNC_W-1:0] func,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    output ctrl_word_t        ctrl_c,
    output logic [4:0]        wreg_c,
    output logic              use_rs_c,
    output logic              use_rt_c,
    output logic              illegal_c
);

    // Opcode/func decode; writes to $0 never enable regwr.
    always_comb begin
        ctrl_c    = CTRL_NOP;
        wreg_c    = '0;
        use_rs_c  = 1'b1;
        use_rt_c  = 1'b0;
        illegal_c = 1'b0;
        case (op)
            OP_RTYPE: begin
                use_rt_c     = 1'b1;
                wreg_c       = rd;
                ctrl_c.regwr = 1'b1;
                case (func)
                    FN_ADD:  ctrl_c.aluc = ALU_ADD;
                    FN_SUB:  ctrl_c.aluc = ALU_SUB;
                    FN_AND:  ctrl_c.aluc = ALU_AND;
                    FN_OR:   ctrl_c.aluc = ALU_OR;
                    FN_SLT:  ctrl_c.aluc = ALU_SLT;
                    default: ctrl_c.regwr = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                wreg_c        = rt;
                ctrl_c.regwr  = 1'b1;
                ctrl_c.extop  = 1'b1;
                ctrl_c.alusrc = 1'b1;
                ctrl_c.aluc   = ALU_ADD;
            end
            OP_ORI: begin
                wreg_c        = rt;
                ctrl_c.regwr  = 1'b1;
                ctrl_c.alusrc = 1'b1;
                ctrl_c.aluc   = ALU_OR;
            end
            OP_LW: begin
                wreg_c          = rt;
                ctrl_c.regwr    = 1'b1;
                ctrl_c.extop    = 1'b1;
                ctrl_c.alusrc   = 1'b1;
                ctrl_c.memtoreg = 1'b1;
                ctrl_c.aluc     = ALU_ADD;
            end
            OP_SW: begin
                use_rt_c      = 1'b1;
                ctrl_c.extop  = 1'b1;
                ctrl_c.alusrc = 1'b1;
                ctrl_c.memwr  = 1'b1;
                ctrl_c.aluc   = ALU_ADD;
            end
            OP_BEQ: begin
                use_rt_c      = 1'b1;
                ctrl_c.extop  = 1'b1;
                ctrl_c.branch = 1'b1;
                ctrl_c.aluc   = ALU_SUB;
            end
            OP_J: begin
                use_rs_c    = 1'b0;
                ctrl_c.jump = 1'b1;
            end
            default: begin
                use_rs_c  = 1'b0;
                illegal_c = 1'b1;
            end
        endcase
        if (wreg_c == '0) begin
            ctrl_c.regwr = 1'b0;
        end
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Registered decode/control stage between IF/ID and EX: decodes, detects
// hazards, inserts bubbles, handles flush/stall, keeps saturating counters.
// Optional: ID_STAGE_CTRL_FWD_EN enables forwarding selects so only load-use
// stalls; otherwise any RAW against ID/EX or EX/MEM produces bubbles.
module id_stage_ctrl
    import id_ctrl_pkg::*;
#(
    parameter int unsigned ALUC_W = 3,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_ctrl_if.slave bus
);

    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rs_a;
    logic [REG_AW-1:0] rt_a;
    logic [15:0]       imm;
    ctrl_word_t        dec_ctrl;
    logic [4:0]        dec_wreg;
    logic              use_rs;
    logic              use_rt;
    logic              illegal;
    logic              load_use;
    logic              hazard;

    logic              ex_valid_q,   ex_valid_d;
    ctrl_word_t        ctrl_q,       ctrl_d;
    logic [REG_AW-1:0] ex_rs_q,      ex_rs_d;
    logic [REG_AW-1:0] ex_rt_q,      ex_rt_d;
    logic [REG_AW-1:0] ex_wreg_q,    ex_wreg_d;
    logic [15:0]       ex_imm_q,     ex_imm_d;
    logic [5:0]        ex_func_q,    ex_func_d;
    logic              ill_op_q,     ill_op_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
`ifdef ID_STAGE_CTRL_FWD_EN
    logic [1:0]        fwd_a_q,      fwd_a_d;
    logic [1:0]        fwd_b_q,      fwd_b_d;
`endif

    // A nonzero destination matching a source register.
    function automatic logic reg_hit(input logic [REG_AW-1:0] dst,
                                     input logic [REG_AW-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + CNT_W'(1);
    endfunction

    assign op   = bus.if_instr[31:26];
    assign rs_a = REG_AW'(bus.if_instr[25:21]);
    assign rt_a = REG_AW'(bus.if_instr[20:16]);
    assign imm  = bus.if_instr[15:0];

    id_decode u_decode (
        .op        (op),
        .func      (imm[5:0]),
        .rt        (bus.if_instr[20:16]),
        .rd        (imm[15:11]),
        .ctrl_c    (dec_ctrl),
        .wreg_c    (dec_wreg),
        .use_rs_c  (use_rs),
        .use_rt_c  (use_rt),
        .illegal_c (illegal)
    );

    assign load_use = ex_valid_q & ctrl_q.memtoreg &
                      ((use_rs & reg_hit(ex_wreg_q, rs_a)) |
                       (use_rt & reg_hit(ex_wreg_q, rt_a)));

`ifdef ID_STAGE_CTRL_FWD_EN
    assign hazard = bus.if_valid & load_use;
`else
    // Without forwarding, wait out any in-flight producer of a source.
    logic raw;
    assign raw = (ex_valid_q & ctrl_q.regwr &
                  ((use_rs & reg_hit(ex_wreg_q, rs_a)) |
                   (use_rt & reg_hit(ex_wreg_q, rt_a)))) |
                 (bus.mem_regwr &
                  ((use_rs & reg_hit(bus.mem_wreg, rs_a)) |
                   (use_rt & reg_hit(bus.mem_wreg, rt_a))));
    assign hazard = bus.if_valid & (load_use | raw);
`endif

    // Flush discards the slot, so ID can always take the next instruction.
    assign bus.id_ready = ~rst & (bus.flush | (~bus.ex_stall & ~hazard));

    // Next-state for ID/EX and counters: flush > ex_stall > hazard > normal.
    always_comb begin
        ex_valid_d   = ex_valid_q;
        ctrl_d       = ctrl_q;
        ex_rs_d      = ex_rs_q;
        ex_rt_d      = ex_rt_q;
        ex_wreg_d    = ex_wreg_q;
        ex_imm_d     = ex_imm_q;
        ex_func_d    = ex_func_q;
        ill_op_d     = ill_op_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
`ifdef ID_STAGE_CTRL_FWD_EN
        fwd_a_d      = fwd_a_q;
        fwd_b_d      = fwd_b_q;
`endif
        if (bus.flush) begin
            ex_valid_d   = 1'b0;
            ctrl_d       = CTRL_NOP;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (bus.ex_stall) begin
            stall_cnt_d  = sat_inc(stall_cnt_q);
        end else if (hazard) begin
            ex_valid_d   = 1'b0;
            ctrl_d       = CTRL_NOP;
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else if (bus.if_valid) begin
            ex_valid_d = ~illegal;
            ctrl_d     = dec_ctrl;
            ex_rs_d    = rs_a;
            ex_rt_d    = rt_a;
            ex_wreg_d  = REG_AW'(dec_wreg);
            ex_imm_d   = imm;
            ex_func_d  = imm[5:0];
            ill_op_d   = ill_op_q | illegal;
`ifdef ID_STAGE_CTRL_FWD_EN
            fwd_a_d = 2'b00;
            if (use_rs && bus.mem_regwr && reg_hit(bus.mem_wreg, rs_a)) begin
                fwd_a_d = 2'b01;
            end else if (use_rs && bus.wb_regwr && reg_hit(bus.wb_wreg, rs_a)) begin
                fwd_a_d = 2'b10;
            end
            fwd_b_d = 2'b00;
            if (use_rt && bus.mem_regwr && reg_hit(bus.mem_wreg, rt_a)) begin
                fwd_b_d = 2'b01;
            end else if (use_rt && bus.wb_regwr && reg_hit(bus.wb_wreg, rt_a)) begin
                fwd_b_d = 2'b10;
            end
`endif
        end else begin
            ex_valid_d = 1'b0;
            ctrl_d     = CTRL_NOP;
        end
    end

    // ID/EX pipeline register, sticky illegal flag and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q   <= 1'b0;
            ctrl_q       <= CTRL_NOP;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_wreg_q    <= '0;
            ex_imm_q     <= '0;
            ex_func_q    <= '0;
            ill_op_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
`ifdef ID_STAGE_CTRL_FWD_EN
            fwd_a_q      <= '0;
            fwd_b_q      <= '0;
`endif
        end else begin
            ex_valid_q   <= ex_valid_d;
            ctrl_q       <= ctrl_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_wreg_q    <= ex_wreg_d;
            ex_imm_q     <= ex_imm_d;
            ex_func_q    <= ex_func_d;
            ill_op_q     <= ill_op_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
`ifdef ID_STAGE_CTRL_FWD_EN
            fwd_a_q      <= fwd_a_d;
            fwd_b_q      <= fwd_b_d;
`endif
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_rs       = ex_rs_q;
    assign bus.ex_rt       = ex_rt_q;
    assign bus.ex_wreg     = ex_wreg_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_func     = ex_func_q;
    assign bus.ex_aluc     = ALUC_W'(ctrl_q.aluc);
    assign bus.ex_regwr    = ctrl_q.regwr;
    assign bus.ex_extop    = ctrl_q.extop;
    assign bus.ex_alusrc   = ctrl_q.alusrc;
    assign bus.ex_memwr    = ctrl_q.memwr;
    assign bus.ex_memtoreg = ctrl_q.memtoreg;
    assign bus.ex_branch   = ctrl_q.branch;
    assign bus.ex_jump     = ctrl_q.jump;
    assign bus.ill_op      = ill_op_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.bubble_cnt  = bubble_cnt_q;
`ifdef ID_STAGE_CTRL_FWD_EN
    assign bus.ex_fwd_a    = fwd_a_q;
    assign bus.ex_fwd_b    = fwd_b_q;
`endif

endmodule

// File: tb/tb_id_stage_ctrl.sv
// Scoreboard bench for id_stage_ctrl (default build): directed vectors push
// hand-computed expectations; monitors compare id_ready and the ID/EX state.
module tb_id_stage_ctrl;

    typedef struct {
        string    nm;
        bit       rdy;
        bit       v;
        int       rs;
        int       wreg;
        int       aluc;
        int       imm;
        bit [6:0] cb;
        bit [6:0] cbm;
        bit       ill;
        int       sc;
        int       bc;
    } exp_t;

    localparam bit [6:0] ALL   = 7'h7F;
    localparam bit [6:0] NOEXT = 7'b1011111;

    localparam logic [31:0] I_ORI   = 32'h350900FF;
    localparam logic [31:0] I_LW    = 32'h8D090000;
    localparam logic [31:0] I_ADD   = 32'h012B5021;
    localparam logic [31:0] I_ILL   = 32'hFC000000;
    localparam logic [31:0] I_ADDIU = 32'h25000005;
    localparam logic [31:0] I_SW    = 32'hAD090004;
    localparam logic [31:0] I_BEQ   = 32'h11090003;
    localparam logic [31:0] I_J     = 32'h08000100;
    localparam logic [31:0] I_UNK   = 32'h01095000;
    localparam logic [31:0] I_SUB   = 32'h012B5023;
    localparam logic [31:0] I_AND   = 32'h01086024;
    localparam logic [31:0] I_SLT   = 32'h0108682A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;
    int   total = 0;
    int   passed = 0;
    exp_t exp_q[$];
    int   q2[$];

    always #5 clk = ~clk;

    id_stage_ctrl_if #(.ALUC_W(3), .REG_AW(5), .CNT_W(16)) bus ();
    id_stage_ctrl_if #(.ALUC_W(3), .REG_AW(5), .CNT_W(2))  bus2 ();

    id_stage_ctrl #(.ALUC_W(3), .REG_AW(5), .CNT_W(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    id_stage_ctrl #(.ALUC_W(3), .REG_AW(5), .CNT_W(2)) u_dut_sat (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    task automatic check(input string nm, input int act, input int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    endtask

    function automatic exp_t mk(input string nm, input bit rdy, input bit v,
                                input int rs, input int wreg, input int aluc,
                                input int imm, input bit [6:0] cb, input bit [6:0] cbm,
                                input bit ill, input int sc, input int bc);
        exp_t e;
        e.nm = nm; e.rdy = rdy; e.v = v; e.rs = rs; e.wreg = wreg;
        e.aluc = aluc; e.imm = imm; e.cb = cb; e.cbm = cbm;
        e.ill = ill; e.sc = sc; e.bc = bc;
        return e;
    endfunction

    // Apply one cycle of inputs and queue what the DUT must show for it.
    task automatic step(input bit r, input bit v, input logic [31:0] ins,
                        input bit st, input bit fl, input bit mr, input exp_t e);
        @(posedge clk);
        #2;
        rst             = r;
        bus.if_valid    = v;
        bus.if_instr    = ins;
        bus.ex_stall    = st;
        bus.flush       = fl;
        bus.mem_regwr   = mr;
        exp_q.push_back(e);
    endtask

    // Monitor: id_ready mid-cycle, registered state just after the edge.
    initial begin : mon
        exp_t e;
        bit [6:0] cb_act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q[0];
                check({e.nm, ".id_ready"}, int'(bus.id_ready), int'(e.rdy));
                @(posedge clk);
                #1;
                check({e.nm, ".ex_valid"}, int'(bus.ex_valid), int'(e.v));
                if (e.rs >= 0)   check({e.nm, ".ex_rs"},   int'(bus.ex_rs),   e.rs);
                if (e.wreg >= 0) check({e.nm, ".ex_wreg"}, int'(bus.ex_wreg), e.wreg);
                if (e.aluc >= 0) check({e.nm, ".ex_aluc"}, int'(bus.ex_aluc), e.aluc);
                if (e.imm >= 0)  check({e.nm, ".ex_imm"},  int'(bus.ex_imm),  e.imm);
                if (e.cbm != 7'd0) begin
                    cb_act = {bus.ex_regwr, bus.ex_extop, bus.ex_alusrc, bus.ex_memwr,
                              bus.ex_memtoreg, bus.ex_branch, bus.ex_jump};
                    check({e.nm, ".ctrl_bits"}, int'(cb_act & e.cbm), int'(e.cb & e.cbm));
                end
                check({e.nm, ".ill_op"},     int'(bus.ill_op),     int'(e.ill));
                check({e.nm, ".stall_cnt"},  int'(bus.stall_cnt),  e.sc);
                check({e.nm, ".bubble_cnt"}, int'(bus.bubble_cnt), e.bc);
                void'(exp_q.pop_front());
            end
        end
    end

    // Monitor for the 2-bit counter instance.
    initial begin : mon2
        int e2;
        forever begin
            @(posedge clk);
            #1;
            if (q2.size() > 0) begin
                e2 = q2.pop_front();
                check("sat.stall_cnt", int'(bus2.stall_cnt), e2);
            end
        end
    end

    // Saturation stimulus: five stall cycles on a 2-bit counter.
    initial begin : drv2
        bus2.if_valid = 1'b0; bus2.if_instr = '0; bus2.ex_stall = 1'b0;
        bus2.flush = 1'b0; bus2.mem_wreg = '0; bus2.mem_regwr = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst2 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            bus2.ex_stall = 1'b1;
            q2.push_back((i >= 2) ? 3 : i + 1);
        end
        @(posedge clk);
        #2 bus2.ex_stall = 1'b0;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin : drv
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.ex_stall = 1'b0;
        bus.flush = 1'b0; bus.mem_wreg = 5'd8; bus.mem_regwr = 1'b0;
        //    rst v  instr    st fl mr      name        rdy v  rs  wreg aluc imm      cb          mask   ill sc bc
        step(1, 0, '0,      0, 0, 0, mk("reset",     0, 0,  0,  0,  0,  0,     7'b0000000, ALL,   0, 0, 0));
        step(0, 1, I_ORI,   0, 0, 0, mk("ori",       1, 1,  8,  9,  3,  'hFF,  7'b1010000, ALL,   0, 0, 0));
        step(0, 1, I_LW,    0, 0, 0, mk("lw",        1, 1,  8,  9, -1,  0,     7'b1010100, NOEXT, 0, 0, 0));
        step(0, 1, I_ADD,   0, 0, 0, mk("lu_bubble", 0, 0, -1, -1, -1, -1,     7'b0000000, 7'd0,  0, 0, 1));
        step(0, 1, I_ADD,   0, 0, 0, mk("add",       1, 1,  9, 10,  0,  'h5021,7'b1000000, NOEXT, 0, 0, 1));
        step(0, 0, '0,      0, 0, 0, mk("idle",      1, 0, -1, -1, -1, -1,     7'b0000000, 7'd0,  0, 0, 1));
        step(0, 1, I_LW,    0, 0, 0, mk("lw2",       1, 1,  8,  9, -1,  0,     7'b1010100, NOEXT, 0, 0, 1));
        step(0, 1, I_ADD,   1, 1, 0, mk("flush",     1, 0, -1, -1, -1, -1,     7'b0000000, 7'd0,  0, 0, 2));
        step(0, 1, I_ORI,   0, 0, 0, mk("ori2",      1, 1,  8,  9,  3,  'hFF,  7'b1010000, ALL,   0, 0, 2));
        step(0, 1, I_ADD,   1, 0, 0, mk("stall1",    0, 1,  8,  9,  3,  'hFF,  7'b1010000, ALL,   0, 1, 2));
        step(0, 1, I_ADD,   1, 0, 0, mk("stall2",    0, 1,  8,  9,  3,  'hFF,  7'b1010000, ALL,   0, 2, 2));
        step(0, 1, I_ADD,   1, 0, 0, mk("stall3",    0, 1,  8,  9,  3,  'hFF,  7'b1010000, ALL,   0, 3, 2));
        step(0, 1, I_ADD,   0, 0, 0, mk("raw_ex",    0, 0, -1, -1, -1, -1,     7'b0000000, 7'd0,  0, 3, 3));
        step(0, 1, I_ADD,   0, 0, 0, mk("add2",      1, 1,  9, 10,  0,  'h5021,7'b1000000, NOEXT, 0, 3, 3));
        step(0, 1, I_ILL,   0, 0, 0, mk("illegal",   1, 0, -1, -1, -1, -1,     7'b0000000, ALL,   1, 3, 3));
        step(0, 1, I_ADDIU, 0, 0, 0, mk("addiu_r0",  1, 1,  8,  0,  0,  5,     7'b0110000, ALL,   1, 3, 3));
        step(0, 1, I_SW,    0, 0, 0, mk("sw",        1, 1,  8, -1, -1,  4,     7'b0011000, NOEXT, 1, 3, 3));
        step(0, 1, I_BEQ,   0, 0, 0, mk("beq",       1, 1,  8, -1,  1,  3,     7'b0000010, NOEXT, 1, 3, 3));
        step(0, 1, I_J,     0, 0, 0, mk("j",         1, 1, -1, -1, -1,  'h100, 7'b0000001, NOEXT, 1, 3, 3));
        step(0, 1, I_UNK,   0, 0, 0, mk("unk_func",  1, 1,  8, -1, -1,  'h5000,7'b0000000, 7'b1000000, 1, 3, 3));
        step(0, 1, I_SUB,   0, 0, 0, mk("sub",       1, 1,  9, 10,  1,  'h5023,7'b1000000, NOEXT, 1, 3, 3));
        step(0, 1, I_AND,   0, 0, 0, mk("and",       1, 1,  8, 12,  2,  'h6024,7'b1000000, NOEXT, 1, 3, 3));
        step(0, 1, I_SLT,   0, 0, 0, mk("slt",       1, 1,  8, 13,  4,  'h682A,7'b1000000, NOEXT, 1, 3, 3));
        step(0, 1, I_ORI,   0, 0, 1, mk("raw_mem",   0, 0, -1, -1, -1, -1,     7'b0000000, 7'd0,  1, 3, 4));
        step(0, 1, I_ORI,   0, 0, 0, mk("ori3",      1, 1,  8,  9,  3,  'hFF,  7'b1010000, ALL,   1, 3, 4));
        step(0, 0, '0,      1, 0, 0, mk("stall4",    0, 1,  8,  9,  3,  'hFF,  7'b1010000, ALL,   1, 4, 4));
        step(1, 0, '0,      1, 0, 0, mk("rst_mid",   0, 0,  0,  0,  0,  0,     7'b0000000, ALL,   0, 0, 0));
        step(0, 1, I_ORI,   0, 0, 0, mk("ori4",      1, 1,  8,  9,  3,  'hFF,  7'b1010000, ALL,   0, 0, 0));
        step(0, 0, '0,      0, 0, 0, mk("idle2",     1, 0, -1, -1, -1, -1,     7'b0000000, 7'd0,  0, 0, 0));
        for (int i = 0; i < 20 && (exp_q.size() > 0 || q2.size() > 0); i++) begin
            @(posedge clk);
            #2;
        end
        check("drain.pending", exp_q.size() + q2.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
